// File: rtl/fixed_to_rgb_pixel.sv
// Converts three signed fixed-point colour channels into one packed RGB pixel.
// Latency: 2 cycles from accepted input to valid_out (one per pipeline stage).
// Backpressure: ready_out drops only when both stages hold pixels and ready_in is low.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start / ready_out   input handshake for r_in, g_in, b_in (signed, Q_BITS fraction bits)
//   valid_out / ready_in output handshake for pixel_out = {r, g, b}
//   sat_clear, sat_count clamped-channel debug counter (saturating) and its clear
module fixed_to_rgb_pixel #(
    parameter int WIDTH     = 24,
    parameter int Q_BITS    = 12,
    parameter int RGB_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   ready_out,
    input  logic [WIDTH-1:0]       r_in,
    input  logic [WIDTH-1:0]       g_in,
    input  logic [WIDTH-1:0]       b_in,
    input  logic                   ready_in,
    output logic                   valid_out,
    output logic [3*RGB_WIDTH-1:0] pixel_out,
    input  logic                   sat_clear,
    output logic [CNT_WIDTH-1:0]   sat_count
);

    // Right shift from the Q format down to the output channel scale.
    localparam int S = Q_BITS - RGB_WIDTH;
    // Half an output LSB, added before the shift for round-half-up.
    localparam logic [WIDTH:0] RND = (WIDTH+1)'(1) << (S - 1);

    // Returns {clamped, channel}. The add is one bit wider than the input so a
    // maximum positive value plus the rounding constant cannot wrap.
    function automatic logic [RGB_WIDTH:0] conv_chan(input logic [WIDTH-1:0] x);
        logic [WIDTH:0]     y;
        logic [RGB_WIDTH:0] res;
        y   = ({1'b0, x} + RND) >> S;
        res = {1'b0, y[RGB_WIDTH-1:0]};
        if (x[WIDTH-1]) begin
            res = {1'b1, {RGB_WIDTH{1'b0}}};
        end else if (|y[WIDTH:RGB_WIDTH]) begin
            res = {1'b1, {RGB_WIDTH{1'b1}}};
        end
        return res;
    endfunction

    logic                   s1_valid_q, s1_valid_d;
    logic [RGB_WIDTH-1:0]   s1_r_q, s1_r_d;
    logic [RGB_WIDTH-1:0]   s1_g_q, s1_g_d;
    logic [RGB_WIDTH-1:0]   s1_b_q, s1_b_d;
    logic                   valid_out_q, valid_out_d;
    logic [3*RGB_WIDTH-1:0] pixel_out_q, pixel_out_d;
    logic [CNT_WIDTH-1:0]   sat_count_q, sat_count_d;

    logic [RGB_WIDTH:0]     r_conv, g_conv, b_conv;
    logic [1:0]             clamp_cnt;
    logic [CNT_WIDTH:0]     cnt_sum;
    logic                   s1_advance;
    logic                   accept;

    assign r_conv    = conv_chan(r_in);
    assign g_conv    = conv_chan(g_in);
    assign b_conv    = conv_chan(b_in);
    assign clamp_cnt = {1'b0, r_conv[RGB_WIDTH]} + {1'b0, g_conv[RGB_WIDTH]}
                     + {1'b0, b_conv[RGB_WIDTH]};

    // Stage 1 can move on whenever stage 2 is empty or draining this cycle,
    // which lets drain, advance and fill all happen on the same edge.
    assign s1_advance = s1_valid_q && (!valid_out_q || ready_in);
    assign ready_out  = !s1_valid_q || s1_advance;
    assign accept     = start && ready_out;

    // One bit of headroom detects overflow so the counter sticks at all-ones.
    assign cnt_sum = {1'b0, sat_count_q} + (CNT_WIDTH+1)'(clamp_cnt);

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_r_d      = s1_r_q;
        s1_g_d      = s1_g_q;
        s1_b_d      = s1_b_q;
        valid_out_d = valid_out_q;
        pixel_out_d = pixel_out_q;
        sat_count_d = sat_count_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_r_d     = r_conv[RGB_WIDTH-1:0];
            s1_g_d     = g_conv[RGB_WIDTH-1:0];
            s1_b_d     = b_conv[RGB_WIDTH-1:0];
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end

        if (s1_advance) begin
            valid_out_d = 1'b1;
            pixel_out_d = {s1_r_q, s1_g_q, s1_b_q};
        end else if (ready_in) begin
            valid_out_d = 1'b0;
        end

        // Clear has priority and swallows any same-cycle increment.
        if (sat_clear) begin
            sat_count_d = '0;
        end else if (accept) begin
            sat_count_d = cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_r_q      <= '0;
            s1_g_q      <= '0;
            s1_b_q      <= '0;
            valid_out_q <= 1'b0;
            pixel_out_q <= '0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_r_q      <= s1_r_d;
            s1_g_q      <= s1_g_d;
            s1_b_q      <= s1_b_d;
            valid_out_q <= valid_out_d;
            pixel_out_q <= pixel_out_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign valid_out = valid_out_q;
    assign pixel_out = pixel_out_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_fixed_to_rgb_pixel.sv
module tb_fixed_to_rgb_pixel;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready_out;
    logic [23:0] r_in, g_in, b_in;
    logic        ready_in;
    logic        valid_out;
    logic [23:0] pixel_out;
    logic        sat_clear;
    logic [15:0] sat_count;

    logic        ready_out_s;
    logic        valid_out_s;
    logic [23:0] pixel_out_s;
    logic [3:0]  sat_count_s;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fixed_to_rgb_pixel u_dut (
        .clk(clk), .rst(rst), .start(start), .ready_out(ready_out),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .ready_in(ready_in),
        .valid_out(valid_out), .pixel_out(pixel_out),
        .sat_clear(sat_clear), .sat_count(sat_count)
    );

    // Same stimulus, narrow counter to exercise saturation.
    fixed_to_rgb_pixel #(.CNT_WIDTH(4)) u_small (
        .clk(clk), .rst(rst), .start(start), .ready_out(ready_out_s),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .ready_in(ready_in),
        .valid_out(valid_out_s), .pixel_out(pixel_out_s),
        .sat_clear(sat_clear), .sat_count(sat_count_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one pixel for one edge; caller guarantees ready_out is high.
    task automatic send(input logic [23:0] r, input logic [23:0] g, input logic [23:0] b);
        start = 1'b1;
        r_in  = r;
        g_in  = g;
        b_in  = b;
        tick();
        start = 1'b0;
    endtask

    localparam logic [23:0] NEG = 24'hFFF000;

    logic [23:0] exp_pix [8];
    logic        pat     [4];

    initial begin
        int sent, recv, occ, cyc, saw_full;
        logic in_acc, out_acc, held;
        logic [23:0] prev;

        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        rst = 1'b1; start = 1'b0; ready_in = 1'b1; sat_clear = 1'b0;
        r_in = '0; g_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_valid", valid_out, 1'b0);
        check("rst_pixel", pixel_out, 24'h0);
        check("rst_sat", sat_count, 16'h0);
        check("rst_ready", ready_out, 1'b1);

        // Plain conversion with rounding: 2048->128, 24->2, 23->1
        send(24'h000800, 24'h000018, 24'h000017);
        check("conv_s1_valid", valid_out, 1'b0);
        tick();
        check("conv_valid", valid_out, 1'b1);
        check("conv_pixel", pixel_out, 24'h800201);
        check("conv_small_pixel", pixel_out_s, 24'h800201);
        tick();
        check("conv_one_cycle", valid_out, 1'b0);
        check("conv_sat", sat_count, 16'h0);

        // Clamp high, clamp negative, round up to exactly 255 without clamping
        send(24'h001000, 24'hFFF000, 24'h000FF7);
        check("sat_count_load", sat_count, 16'd2);
        tick();
        check("sat_valid", valid_out, 1'b1);
        check("sat_pixel", pixel_out, 24'hFF00FF);
        tick();

        // Backpressure stream with ready_in pattern 1,0,0,1
        for (int i = 0; i < 8; i++) begin
            exp_pix[i] = {8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i)};
        end
        sent = 0; recv = 0; occ = 0; saw_full = 0;
        for (cyc = 0; cyc < 100 && recv < 8; cyc++) begin
            ready_in = pat[cyc % 4];
            start    = (sent < 8);
            r_in     = 24'((8'h10 + sent) << 4);
            g_in     = 24'((8'h20 + sent) << 4);
            b_in     = 24'((8'h30 + sent) << 4);
            #1;
            check("bp_ready_out", ready_out, !(occ == 2 && !ready_in));
            if (!ready_out) saw_full = 1;
            in_acc  = start && ready_out;
            out_acc = valid_out && ready_in;
            held    = valid_out && !ready_in;
            prev    = pixel_out;
            if (out_acc) begin
                check("bp_pixel", pixel_out, (recv < 8) ? exp_pix[recv] : 24'hx);
                recv++;
            end
            tick();
            if (in_acc) begin
                sent++;
                occ++;
            end
            if (out_acc) occ--;
            if (held) check("bp_stable", pixel_out, prev);
        end
        start    = 1'b0;
        ready_in = 1'b1;
        check("bp_all_received", recv, 8);
        check("bp_saw_full", saw_full, 1);
        tick();
        check("bp_no_dup", valid_out, 1'b0);
        check("bp_sat", sat_count, 16'd2);

        // Reset while both stages hold pixels
        ready_in = 1'b0;
        send(24'hFFFFFF, 24'h000100, 24'h000100);
        send(24'h000200, 24'h000200, 24'h000200);
        #1;
        check("mid_full_valid", valid_out, 1'b1);
        check("mid_full_ready", ready_out, 1'b0);
        check("mid_sat", sat_count, 16'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_valid", valid_out, 1'b0);
        check("mid_rst_sat", sat_count, 16'h0);
        check("mid_rst_ready", ready_out, 1'b1);
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_stale", valid_out, 1'b0);
        end

        // Counter accumulation, clear priority, and saturation on the narrow instance
        for (int i = 0; i < 3; i++) send(NEG, NEG, NEG);
        check("cnt_nine", sat_count, 16'd9);
        check("cnt_small_nine", sat_count_s, 4'd9);
        sat_clear = 1'b1;
        send(NEG, NEG, NEG);
        sat_clear = 1'b0;
        check("cnt_clear_wins", sat_count, 16'h0);
        check("cnt_small_clear", sat_count_s, 4'h0);
        for (int i = 0; i < 4; i++) send(NEG, NEG, NEG);
        send(NEG, NEG, 24'h000100);
        check("cnt_small_14", sat_count_s, 4'd14);
        send(NEG, NEG, NEG);
        check("cnt_small_stick", sat_count_s, 4'd15);
        check("cnt_wide_17", sat_count, 16'd17);
        send(NEG, NEG, NEG);
        check("cnt_small_hold", sat_count_s, 4'd15);
        check("small_ready", ready_out_s, 1'b1);
        repeat (2) tick();
        check("small_drained", valid_out_s, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
